mem_delay_slave: RTL and testbench



---
 rtl/mem_delay_slave.sv | 132 +++++++++++++
 tb/tb_mem_delay_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_delay_slave.sv
// Single-outstanding memory front end: holds each request for a fixed wait (or, with
// RAND_DELAY_EN defined, an LFSR-derived wait), then does a one-cycle access and returns the data.
module mem_delay_slave #(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter int         CNT_W       = 8,
    parameter int         FIXED_DELAY = 4,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter logic [7:0] RAND_MASK   = 8'h0F
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic                i_req_wen,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wmask,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_mem_en,
    output logic                o_mem_wen,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, FETCH, RESP} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] delay_d;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wen_q;

`ifdef RAND_DELAY_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_masked;

    // Galois LFSR free-runs so the delay seen by a request depends on when it arrives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    assign lfsr_masked = lfsr_q & RAND_MASK;
    assign delay_d     = CNT_W'(lfsr_masked);
`else
    assign delay_d = CNT_W'(FIXED_DELAY);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        o_req_ready = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_wen   = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    next_state = (delay_d == '0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                // Counter starts at 0 in the first WAIT cycle, so D-1 marks the last one.
                if (cnt_q == delay_q - CNT_W'(1)) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                o_mem_en   = 1'b1;
                o_mem_wen  = wen_q;
                next_state = FETCH;
            end
            FETCH: begin
                next_state = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            delay_q     <= '0;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wmask <= '0;
            o_rsp_rdata <= '0;
        end else begin
            if (state == IDLE && i_req_valid) begin
                delay_q     <= delay_d;
                cnt_q       <= '0;
                wen_q       <= i_req_wen;
                o_mem_addr  <= i_req_addr;
                o_mem_wdata <= i_req_wdata;
                o_mem_wmask <= i_req_wen ? i_req_wmask : '0;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Read data arrives the cycle after the strobe; writes return zero.
            if (state == FETCH) begin
                o_rsp_rdata <= wen_q ? '0 : i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_delay_slave.sv
// Bench for mem_delay_slave: three instances (fixed delays 4, 0, 8) run a vector table plus reset
// and backpressure sequences; with RAND_DELAY_EN defined, a reference LFSR predicts each delay.
`timescale 1ns/1ps
module tb_mem_delay_slave;

    localparam int          NDUT   = 3;
    localparam logic [31:0] RD_KEY = 32'h5EAD_BEEF;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          hold;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wmask;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          delay;
    } exp_t;

    logic        clk;
    logic        rst       [NDUT];
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic        req_wen   [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [3:0]  req_wmask [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        mem_en    [NDUT];
    logic        mem_wen   [NDUT];
    logic [31:0] mem_addr  [NDUT];
    logic [31:0] mem_wdata [NDUT];
    logic [3:0]  mem_wmask [NDUT];
    logic [31:0] mem_rdata [NDUT];

    exp_t sb [$];
    vec_t vecs [6];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_delay_slave #(
            .FIXED_DELAY((g == 0) ? 4 : ((g == 1) ? 0 : 8))
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst[g]),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wen   (req_wen[g]),
            .i_req_wdata (req_wdata[g]),
            .i_req_wmask (req_wmask[g]),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready[g]),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_mem_en    (mem_en[g]),
            .o_mem_wen   (mem_wen[g]),
            .o_mem_addr  (mem_addr[g]),
            .o_mem_wdata (mem_wdata[g]),
            .o_mem_wmask (mem_wmask[g]),
            .i_mem_rdata (mem_rdata[g])
        );
    end

    // Synchronous memory model: data is valid only in the cycle after a read strobe.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            mem_rdata[k] <= (mem_en[k] && !mem_wen[k]) ? (mem_addr[k] ^ RD_KEY) : 32'hBAD0_BAD0;
        end
    end

`ifdef RAND_DELAY_EN
    logic [7:0] ref_lfsr;
    bit         seen [16];

    always @(posedge clk) begin
        if (rst[0]) begin
            ref_lfsr <= 8'hA5;
        end else begin
            ref_lfsr <= {1'b0, ref_lfsr[7:1]} ^ (ref_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end
`endif

    function automatic int fixed_delay(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 0 : 8);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one request in an IDLE cycle, records the expectation, then scrambles the inputs.
    task automatic applyStimulus(input vec_t v, input int d, output int used_delay);
        exp_t e;
        int   dly;
        dly = d;
        @(negedge clk);
`ifdef RAND_DELAY_EN
        dly = int'(ref_lfsr & 8'h0F);
`endif
        used_delay = dly;
        checkOutput("req_ready_idle", 32'(req_ready[v.k]), 32'd1);
        req_valid[v.k] = 1'b1;
        req_addr[v.k]  = v.addr;
        req_wen[v.k]   = v.wen;
        req_wdata[v.k] = v.wdata;
        req_wmask[v.k] = v.wmask;
        rsp_ready[v.k] = (v.hold == 0);
        e.rdata = v.exp_rdata;
        e.addr  = v.addr;
        e.wen   = v.wen;
        e.wdata = v.wdata;
        e.wmask = v.exp_wmask;
        e.delay = dly;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid[v.k] = 1'b0;
        req_addr[v.k]  = v.addr ^ 32'h0000_00C0;
        req_wen[v.k]   = ~v.wen;
        req_wdata[v.k] = ~v.wdata;
        req_wmask[v.k] = ~v.wmask;
    endtask

    task automatic observeTxn(input int k, input int hold);
        exp_t        e;
        int          cyc;
        int          en_cycle;
        int          en_count;
        int          valid_cycle;
        logic        m_wen;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_wmask;
        cyc = 0; en_cycle = -1; en_count = 0; valid_cycle = -1;
        m_wen = 1'b0; m_addr = '0; m_wdata = '0; m_wmask = '0;
        while (valid_cycle < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_en[k]) begin
                en_count++;
                en_cycle = cyc;
                m_wen    = mem_wen[k];
                m_addr   = mem_addr[k];
                m_wdata  = mem_wdata[k];
                m_wmask  = mem_wmask[k];
            end
            if (rsp_valid[k]) valid_cycle = cyc;
        end
        e = sb.pop_front();
        if (valid_cycle < 0) begin
            checkOutput("rsp_valid_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("mem_en_cycle", en_cycle, e.delay + 1);
        checkOutput("mem_en_count", en_count, 32'd1);
        checkOutput("mem_wen", 32'(m_wen), 32'(e.wen));
        checkOutput("mem_addr", m_addr, e.addr);
        checkOutput("mem_wdata", m_wdata, e.wdata);
        checkOutput("mem_wmask", 32'(m_wmask), 32'(e.wmask));
        checkOutput("rsp_valid_cycle", valid_cycle, e.delay + 3);
        checkOutput("rsp_rdata", rsp_rdata[k], e.rdata);
        checkOutput("rsp_req_ready", 32'(req_ready[k]), 32'd0);
        if (hold > 0) begin
            for (int i = 1; i <= hold; i++) begin
                @(negedge clk);
                checkOutput("bp_rsp_valid", 32'(rsp_valid[k]), 32'd1);
                checkOutput("bp_rdata_stable", rsp_rdata[k], e.rdata);
                checkOutput("bp_req_ready", 32'(req_ready[k]), 32'd0);
            end
            rsp_ready[k] = 1'b1;
        end
        @(negedge clk);
        checkOutput("post_rsp_req_ready", 32'(req_ready[k]), 32'd1);
        checkOutput("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    endtask

    initial begin
        int   d;
        int   flag_en;
        int   flag_rsp;
        vec_t v;
        checks = 0;
        errors = 0;
        for (int k = 0; k < NDUT; k++) begin
            rst[k]       = 1'b1;
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            req_wen[k]   = 1'b0;
            req_wdata[k] = '0;
            req_wmask[k] = '0;
            rsp_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput("reset_req_ready", 32'(req_ready[k]), 32'd1);
            checkOutput("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            checkOutput("reset_mem_en", 32'(mem_en[k]), 32'd0);
            checkOutput("reset_mem_wen", 32'(mem_wen[k]), 32'd0);
            checkOutput("reset_mem_wmask", 32'(mem_wmask[k]), 32'd0);
            checkOutput("reset_rsp_rdata", rsp_rdata[k], 32'd0);
            checkOutput("reset_mem_addr", mem_addr[k], 32'd0);
            checkOutput("reset_mem_wdata", mem_wdata[k], 32'd0);
            rst[k] = 1'b0;
        end

`ifdef RAND_DELAY_EN
        for (int n = 0; n < 100; n++) begin
            v = '{0, 32'(n * 4), 1'b0, 32'h0, 4'hF, 0, 32'(n * 4) ^ RD_KEY, 4'h0};
            applyStimulus(v, 0, d);
            seen[d] = 1'b1;
            observeTxn(0, 0);
        end
        for (int j = 0; j < 16; j++) begin
            checkOutput("delay_value_seen", 32'(seen[j]), 32'd1);
        end
`else
        vecs[0] = '{0, 32'h8000_0000, 1'b0, 32'h1111_1111, 4'hF, 0, 32'hDEAD_BEEF, 4'h0};
        vecs[1] = '{1, 32'h0000_0010, 1'b1, 32'h1234_5678, 4'h3, 0, 32'h0000_0000, 4'h3};
        vecs[2] = '{0, 32'h0000_0040, 1'b0, 32'hCAFE_F00D, 4'h5, 6, 32'h5EAD_BEAF, 4'h0};
        vecs[3] = '{1, 32'h1234_5670, 1'b0, 32'h0000_0000, 4'hF, 2, 32'h4C99_E89F, 4'h0};
        vecs[4] = '{2, 32'hFFFF_FFFC, 1'b1, 32'hA5A5_5A5A, 4'h8, 1, 32'h0000_0000, 4'h8};
        vecs[5] = '{2, 32'h0000_0100, 1'b0, 32'h0000_0000, 4'h0, 0, 32'h5EAD_BFEF, 4'h0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], fixed_delay(vecs[i].k), d);
            observeTxn(vecs[i].k, vecs[i].hold);
        end

        // Reset lands in the third WAIT cycle of an 8-cycle delay; the request must vanish.
        applyStimulus(vecs[5], 8, d);
        void'(sb.pop_back());
        flag_en  = 0;
        flag_rsp = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (mem_en[2]) flag_en = 1;
            if (rsp_valid[2]) flag_rsp = 1;
        end
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        checkOutput("rst_mid_req_ready", 32'(req_ready[2]), 32'd1);
        checkOutput("rst_mid_mem_addr", mem_addr[2], 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_en[2]) flag_en = 1;
            if (rsp_valid[2]) flag_rsp = 1;
        end
        checkOutput("rst_mid_no_mem_en", flag_en, 32'd0);
        checkOutput("rst_mid_no_rsp", flag_rsp, 32'd0);
        applyStimulus(vecs[5], 8, d);
        observeTxn(2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
